// File: rtl/approx_add_rr_scheduler.sv
// rtl/approx_add_rr_scheduler.sv - round-robin shared 8-bit approximate adder with registered tagged result
// Optional exact-sum error monitor: APPROX_ERR_MON_EN
module approx_add_rr_scheduler #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [8:0]           res_sum,
    output logic [2:0]           res_id,
`ifdef APPROX_ERR_MON_EN
    output logic                 res_err,
    output logic [15:0]          err_cnt,
`endif
    output logic                 busy
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [8:0]  r_sum;
    logic [2:0]  r_id;
    logic [2:0]  r_ptr;
    logic        w_acc;
    logic        w_found;
    logic        w_grant;
    logic [2:0]  w_win;
    logic [2:0]  w_ptr_nxt;
    logic [3:0]  w_cand;
    logic [7:0]  w_a;
    logic [7:0]  w_b;
    logic [8:0]  w_sum;

    // Odd carries look back only two bit positions, so ripple chains are cut short.
    function automatic logic [8:0] approx_add(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] g;
        logic [8:1] c;
        logic [8:0] s;
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[1] = g[0];
        for (int i = 2; i <= 8; i++) begin
            if (i % 2 == 0)
                c[i] = g[i-1] | (p[i-1] & c[i-1]);
            else
                c[i] = g[i-1] | (p[i-1] & g[i-2]);
        end
        s[0] = p[0];
        for (int i = 1; i <= 7; i++)
            s[i] = c[i] ^ p[i];
        s[8] = c[8];
        return s;
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_a     = '0;
        w_b     = '0;
        w_cand  = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_cand = {1'b0, r_ptr} + 4'(j);
            if (w_cand >= 4'(NREQ))
                w_cand = w_cand - 4'(NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && req_valid[i] && (w_cand == 4'(i))) begin
                    w_found = 1'b1;
                    w_win   = 3'(i);
                    w_a     = req_a[8*i +: 8];
                    w_b     = req_b[8*i +: 8];
                end
            end
        end
    end

    assign w_sum     = approx_add(w_a, w_b);
    assign w_ptr_nxt = (w_win == 3'(NREQ-1)) ? 3'd0 : w_win + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_acc       = (r_state == EMPTY) | res_ready;
        w_grant     = w_acc & w_found & ~rst;
        req_ready   = '0;
        for (int i = 0; i < NREQ; i++)
            req_ready[i] = w_grant && (w_win == 3'(i));
        case (r_state)
            EMPTY:   if (w_grant) w_state_nxt = FULL;
            FULL:    if (res_ready && !w_grant) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
            r_id  <= '0;
            r_ptr <= '0;
        end else if (w_grant) begin
            r_sum <= w_sum;
            r_id  <= w_win;
            r_ptr <= w_ptr_nxt;
        end
    end

`ifdef APPROX_ERR_MON_EN
    logic [8:0]  w_exact;
    logic        r_err;
    logic [15:0] r_err_cnt;

    assign w_exact = {1'b0, w_a} + {1'b0, w_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_grant)
                r_err <= (w_exact != w_sum);
            if ((r_state == FULL) && res_ready && r_err && (r_err_cnt != 16'hFFFF))
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign res_err = r_err;
    assign err_cnt = r_err_cnt;
`endif

    assign res_valid = (r_state == FULL);
    assign res_sum   = r_sum;
    assign res_id    = r_id;
    assign busy      = res_valid | (|req_valid);

endmodule

// File: tb/tb_approx_add_rr_scheduler.sv
// tb/tb_approx_add_rr_scheduler.sv - directed self-checking bench for approx_add_rr_scheduler
module tb_approx_add_rr_scheduler;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [8:0]        res_sum;
    logic [2:0]        res_id;
    logic              busy;
`ifdef APPROX_ERR_MON_EN
    logic              res_err;
    logic [15:0]       err_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    approx_add_rr_scheduler #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
`ifdef APPROX_ERR_MON_EN
        .res_err   (res_err),
        .err_cnt   (err_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        set_ops(0, 8'h01, 8'h01);
        step();
        step();
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_res_sum",   32'(res_sum),   32'h0);
        check("rst_res_id",    32'(res_id),    32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_busy",      32'(busy),      32'h1);
`ifdef APPROX_ERR_MON_EN
        check("rst_err_cnt",   32'(err_cnt),   32'h0);
`endif

        // first grant after release goes to requester 0
        rst       = 1'b0;
        res_ready = 1'b1;
        #1;
        check("t1_req_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        check("t1_res_valid", 32'(res_valid), 32'h1);
        check("t1_res_id",    32'(res_id),    32'h0);
        check("t1_res_sum",   32'(res_sum),   32'h002);
        step();
        check("t1_drain",     32'(res_valid), 32'h0);
        check("t1_idle_busy", 32'(busy),      32'h0);

        // requester 2 alone, ptr=1
        set_ops(2, 8'h12, 8'h21);
        req_valid = 4'b0100;
        #1;
        check("t2_req_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0000;
        check("t2_res_valid", 32'(res_valid), 32'h1);
        check("t2_res_sum",   32'(res_sum),   32'h033);
        check("t2_res_id",    32'(res_id),    32'h2);
`ifdef APPROX_ERR_MON_EN
        check("t2_res_err",   32'(res_err),   32'h0);
`endif

        // requester 0, carry truncation case; ptr=3 so wrap to 0
        set_ops(0, 8'h0F, 8'h01);
        req_valid = 4'b0001;
        #1;
        check("t3_req_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        check("t3_res_sum",   32'(res_sum),   32'h008);
        check("t3_res_id",    32'(res_id),    32'h0);
`ifdef APPROX_ERR_MON_EN
        check("t3_res_err",   32'(res_err),   32'h1);
`endif
        step();
        check("t3_drain",     32'(res_valid), 32'h0);
`ifdef APPROX_ERR_MON_EN
        check("t3_err_cnt",   32'(err_cnt),   32'h1);
`endif

        // bring ptr back to 0 via a grant to requester 3
        for (int i = 0; i < NREQ; i++)
            set_ops(i, 8'((i + 1) * 16), 8'h00);
        req_valid = 4'b1000;
        step();
        check("t4_pre_id",  32'(res_id),  32'h3);
        check("t4_pre_sum", 32'(res_sum), 32'h040);

        // all valid, res_ready=1: 0,1,2,3,0 with no bubbles
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4_rr_valid", 32'(res_valid), 32'h1);
            check("t4_rr_id",    32'(res_id),    32'(k % 4));
            check("t4_rr_sum",   32'(res_sum),   32'(((k % 4) + 1) * 16));
        end

        // stall three cycles with ptr frozen at 1
        res_ready = 1'b0;
        #1;
        check("t5_stall_ready", 32'(req_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_stall_valid", 32'(res_valid), 32'h1);
            check("t5_stall_id",    32'(res_id),    32'h0);
            check("t5_stall_sum",   32'(res_sum),   32'h010);
            check("t5_stall_rdy",   32'(req_ready), 32'h0);
        end
        res_ready = 1'b1;
        #1;
        check("t5_release_ready", 32'(req_ready), 32'b0010);
        step();
        check("t5_next_id",  32'(res_id),  32'h1);
        check("t5_next_sum", 32'(res_sum), 32'h020);
`ifdef APPROX_ERR_MON_EN
        check("t5_err_cnt",  32'(err_cnt), 32'h1);
`endif

        // async reset while stalled
        res_ready = 1'b0;
        step();
        check("t6_pre_valid", 32'(res_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(res_valid), 32'h0);
        check("t6_async_sum",   32'(res_sum),   32'h0);
        check("t6_async_id",    32'(res_id),    32'h0);
        check("t6_async_ready", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;
        #1;
        check("t6_ptr_zero", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        res_ready = 1'b1;
        step();
        check("t6_end_valid", 32'(res_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
